// File: rtl/switch_debounce_if.sv
// switch_debounce_if: debounced switch bus between the debounce stage and
// the memory-mapped switch reader. The master drives the clean levels and
// change flags; the slave (reader/CPU side) drives the change-clear request.
interface switch_debounce_if #(
    parameter int N_SW = 24
) ();
    logic [N_SW-1:0] switch_o;
    logic [N_SW-1:0] change_o;
    logic            irq_o;
    logic            chg_clr;
    logic [N_SW-1:0] chg_clr_mask;

    modport master (
        output switch_o,
        output change_o,
        output irq_o,
        input  chg_clr,
        input  chg_clr_mask
    );

    modport slave (
        input  switch_o,
        input  change_o,
        input  irq_o,
        output chg_clr,
        output chg_clr_mask
    );
endinterface

// File: rtl/switch_debounce.sv
// switch_debounce: synchronises raw DIP switch lines, filters contact bounce
// with per-bit stability counters advanced by a shared prescaler tick, and
// drives the clean levels onto the reader bus.
// Optional feature macro: SWDB_CHANGE_LATCH_EN -- when defined, a sticky
// per-bit change latch with mask-selected clear and an OR'd interrupt is
// built; otherwise change_o/irq_o are constant 0 and no latch flops exist.
module switch_debounce #(
    parameter int N_SW         = 24,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic                switclk,
    input  logic                switrst,
    input  logic [N_SW-1:0]     switch_raw,
    switch_debounce_if.master   bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    logic [N_SW-1:0] s1_q;
    logic [N_SW-1:0] s2_q;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic            tick_s;
    logic [CW-1:0]   cnt_q [N_SW];
    logic [CW-1:0]   cnt_d [N_SW];
    logic [N_SW-1:0] sw_q;
    logic [N_SW-1:0] sw_d;

    // Two-flop synchroniser; only the second stage feeds the filter.
    always_ff @(posedge switclk or posedge switrst) begin
        if (switrst) begin
            s1_q <= {N_SW{1'b0}};
            s2_q <= {N_SW{1'b0}};
        end else begin
            s1_q <= switch_raw;
            s2_q <= s1_q;
        end
    end

    // Free-running prescaler; tick on the last count, wrapping on the same edge.
    always_comb begin
        tick_s = (presc_q == TICK_LAST);
        if (tick_s) begin
            presc_d = {PW{1'b0}};
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // Per-bit stability filter: any agreement restarts the count, a full run
    // of mismatching ticks accepts the new level.
    always_comb begin
        sw_d = sw_q;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == sw_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (tick_s) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sw_d[i]  = s2_q[i];
                    cnt_d[i] = {CW{1'b0}};
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Prescaler, stability counters and debounced level registers.
    always_ff @(posedge switclk or posedge switrst) begin
        if (switrst) begin
            presc_q <= {PW{1'b0}};
            sw_q    <= {N_SW{1'b0}};
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            presc_q <= presc_d;
            sw_q    <= sw_d;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.switch_o = sw_q;

`ifdef SWDB_CHANGE_LATCH_EN
    logic [N_SW-1:0] chg_q;
    logic [N_SW-1:0] chg_d;
    logic [N_SW-1:0] clr_sel_s;
    logic            irq_q;

    // Sticky change flags: a flip on this edge overrides a simultaneous clear.
    always_comb begin
        if (bus.chg_clr) begin
            clr_sel_s = bus.chg_clr_mask;
        end else begin
            clr_sel_s = {N_SW{1'b0}};
        end
        chg_d = (chg_q & ~clr_sel_s) | (sw_d ^ sw_q);
    end

    // Change flags and interrupt registered together so irq tracks change_o.
    always_ff @(posedge switclk or posedge switrst) begin
        if (switrst) begin
            chg_q <= {N_SW{1'b0}};
            irq_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
            irq_q <= |chg_d;
        end
    end

    assign bus.change_o = chg_q;
    assign bus.irq_o    = irq_q;
`else
    logic unused_clr_s;
    assign unused_clr_s = ^{bus.chg_clr, bus.chg_clr_mask};
    assign bus.change_o = {N_SW{1'b0}};
    assign bus.irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed test-plan scenarios plus randomized switch
// activity, checked every cycle against a tick-counting reference model.
module tb_switch_debounce;
    localparam int N_SW = 24;
    localparam int TD   = 4;
    localparam int ST   = 3;
`ifdef SWDB_CHANGE_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_SW-1:0] raw = 24'h0;

    switch_debounce_if #(.N_SW(N_SW)) sw_bus ();

    switch_debounce #(
        .N_SW(N_SW), .TICK_DIV(TD), .STABLE_TICKS(ST)
    ) dut (
        .switclk    (clk),
        .switrst    (rst),
        .switch_raw (raw),
        .bus        (sw_bus.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level is accepted on a tick once the current
    // uninterrupted mismatch run contains STABLE_TICKS tick cycles.
    logic [N_SW-1:0] m_s1 = '0, m_s2 = '0, m_out = '0, m_chg = '0;
    int              cyc = 0;
    int              run_start [N_SW];

    task automatic model_step();
        logic [N_SW-1:0] flip;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_chg = '0; cyc = 0;
            for (int i = 0; i < N_SW; i++) run_start[i] = 0;
        end else begin
            flip = '0;
            for (int i = 0; i < N_SW; i++) begin
                if (m_s2[i] == m_out[i]) begin
                    run_start[i] = cyc + 1;
                end else if (cyc % TD == TD - 1) begin
                    if ((cyc + 1) / TD - run_start[i] / TD >= ST) begin
                        flip[i] = 1'b1;
                        run_start[i] = cyc + 1;
                    end
                end
            end
            m_out = m_out ^ flip;
            if (LATCH) begin
                m_chg = (m_chg & ~(sw_bus.chg_clr ? sw_bus.chg_clr_mask : 24'h0)) | flip;
            end
            m_s2 = m_s1;
            m_s1 = raw;
            cyc++;
        end
    endtask

    initial begin
        for (int i = 0; i < N_SW; i++) run_start[i] = 0;
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Continuous comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            check_val("switch_o", 32'(sw_bus.switch_o), 32'(m_out));
            check_val("change_o", 32'(sw_bus.change_o), 32'(m_chg));
            check_val("irq_o",    32'(sw_bus.irq_o),    32'(|m_chg));
        end
    end

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sw_bus.chg_clr = 1'b0;
        go(2);
        rst = 1'b0;
    endtask

    initial begin
        sw_bus.chg_clr      = 1'b0;
        sw_bus.chg_clr_mask = 24'h0;
        go(3);

        // Clean edge on bit 0
        raw = 24'h0;
        do_reset();
        check_val("rst_switch", 32'(sw_bus.switch_o), 32'h0);
        check_val("rst_irq",    32'(sw_bus.irq_o),    32'h0);
        go(20);
        raw[0] = 1'b1;
        go(11);
        check_val("clean_early", 32'(sw_bus.switch_o), 32'h0);
        go(4);
        check_val("clean_late", 32'(sw_bus.switch_o), 32'h1);

        // Bounce on bit 5 never accepted
        raw = 24'h0;
        do_reset();
        go(2);
        for (int k = 0; k < 14; k++) begin
            raw[5] = ~raw[5];
            go(3);
        end
        raw[5] = 1'b0;
        go(20);
        check_val("bounce_sw",  32'(sw_bus.switch_o), 32'h0);
        check_val("bounce_chg", 32'(sw_bus.change_o), 32'h0);

        // Multi-bit step, all bits on one edge
        raw = 24'h0;
        do_reset();
        go(20);
        raw = 24'hA5_00FF;
        go(11);
        check_val("multi_before", 32'(sw_bus.switch_o), 32'h0);
        go(1);
        check_val("multi_after",  32'(sw_bus.switch_o), 32'hA5_00FF);

        // Reset mid-count on bit 3
        raw = 24'h0;
        do_reset();
        go(2);
        raw[3] = 1'b1;
        go(8);
        rst = 1'b1;
        #1;
        check_val("midrst_sw",  32'(sw_bus.switch_o), 32'h0);
        check_val("midrst_chg", 32'(sw_bus.change_o), 32'h0);
        go(2);
        rst = 1'b0;
        go(11);
        check_val("midrst_early", 32'(sw_bus.switch_o), 32'h0);
        go(1);
        check_val("midrst_late",  32'(sw_bus.switch_o), 32'h8);
        check_val("midrst_flag",  32'(sw_bus.change_o), LATCH ? 32'h8 : 32'h0);

        // Change latch clear and set-wins on bit 7
        raw = 24'h0;
        do_reset();
        go(4);
        raw[7] = 1'b1;
        go(12);
        check_val("latch_irq_set", 32'(sw_bus.irq_o), 32'(LATCH));
        sw_bus.chg_clr      = 1'b1;
        sw_bus.chg_clr_mask = 24'h00_0080;
        go(1);
        sw_bus.chg_clr = 1'b0;
        check_val("latch_irq_clr", 32'(sw_bus.irq_o), 32'h0);
        raw[7] = 1'b0;
        go(10);
        sw_bus.chg_clr = 1'b1;
        go(1);
        sw_bus.chg_clr = 1'b0;
        check_val("latch_setwins", 32'(sw_bus.change_o[7]), 32'(LATCH));
        check_val("latch_sw_fell", 32'(sw_bus.switch_o), 32'h0);

        // Randomized activity with sparse flips, clears and one reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sw_bus.chg_clr = 1'b0;
            if (c == 1500) rst = 1'b1;
            if (c == 1503) rst = 1'b0;
            if ($urandom_range(0, 7) == 0) raw[$urandom_range(0, N_SW - 1)] ^= 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                sw_bus.chg_clr      = 1'b1;
                sw_bus.chg_clr_mask = 24'($urandom);
            end
        end
        go(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/switch_debounce.md
# switch_debounce

Input conditioning stage between the board DIP switches and the memory-mapped switch reader. It synchronises the 24 raw switch lines into `switclk`, filters contact bounce with per-bit stability counters driven by a shared prescaler tick, and presents a clean `switch_o[23:0]` bus that connects directly to the reader's `switch_i`. An optional sticky change-latch with interrupt lets the CPU detect switch activity without polling.

## Interface
- `N_SW`, 24, number of switch lines.
- `TICK_DIV`, 100000, prescaler period in `switclk` cycles (1 ms at 100 MHz); must be ≥1.
- `STABLE_TICKS`, 10, consecutive mismatching ticks required to accept a new level; must be ≥1.
- `switclk`  in  1  clock, all state on posedge.
- `switrst`  in  1  reset, asynchronous, active-high.
- `switch_raw`  in  N_SW  raw board switch pins, asynchronous.
- `switch_o`  out  N_SW  debounced switch levels, feeds reader `switch_i`.
- `chg_clr`  in  1  one-cycle pulse; clears the change bits selected by `chg_clr_mask` (change-latch builds only).
- `chg_clr_mask`  in  N_SW  per-bit clear select.
- `change_o`  out  N_SW  sticky per-bit change flags.
- `irq_o`  out  1  OR of `change_o`.

## Operation
- Synchroniser: 2 flops per bit (`s1`, `s2`); only `s2` is used downstream.
- Prescaler: counter 0..TICK_DIV-1, free-running from reset; `tick` = (count == TICK_DIV-1); wraps to 0 on the same edge. `TICK_DIV`=1 gives `tick` on every cycle.
- Per bit i, counter `cnt[i]` has width clog2(STABLE_TICKS+1):
  - `s2[i] == switch_o[i]`: `cnt[i]` <= 0 on any cycle, tick or not. A single bounce back restarts the count.
  - Mismatch and `tick` and `cnt[i] == STABLE_TICKS-1`: `switch_o[i]` <= `s2[i]`, `cnt[i]` <= 0.
  - Mismatch and `tick`, otherwise: `cnt[i]` += 1.
  - Mismatch, no tick: hold.
- Bits are fully independent; several may flip on the same tick.
- Change latch: `change_o[i]` is set on the cycle `switch_o[i]` flips. `chg_clr` with mask bit i clears it. On simultaneous set and clear, set wins.
- Reset mid-operation: all state is cleared immediately and asynchronously. Switches held ON at reset release produce a legitimate 0→1 transition after the debounce period; this also sets `change_o` when the latch is compiled in.

## Timing
- Reset values: `switch_o`=0, `change_o`=0, `irq_o`=0, `s1`/`s2`=0, prescaler=0, all `cnt`=0.
- Synchroniser latency: 2 cycles from a raw edge to `s2`.
- Debounce latency after `s2` settles: between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles, depending on prescaler phase.
- `switch_o` is registered. The reader samples on negedge, so there is half a cycle of setup margin.
- `change_o` updates on the same edge as `switch_o`; `irq_o` is registered with `change_o` (same cycle, no extra delay).
- `chg_clr` takes effect on the next posedge; the flag reads 0 the following cycle.

## Configuration
- `SWDB_CHANGE_LATCH_EN` defined: change latch, `chg_clr` handling and `irq_o` are compiled in as described above.
- Not defined: `change_o` and `irq_o` are tied to constant 0. `chg_clr` and `chg_clr_mask` are ignored. No change-latch flops are generated.

## Test plan
Benches use `TICK_DIV`=4 and `STABLE_TICKS`=3; ticks fall on cycles 3, 7, 11, … after reset release.
- Clean edge: `switch_raw`[0] 0→1 at cycle 20 and held → `switch_o`[0]=1 no earlier than cycle 31 and no later than cycle 34; all other bits stay 0.
- Bounce: `switch_raw`[5] toggles every 3 cycles for 40 cycles, then settles at 0 → `switch_o`[5] stays 0 throughout and `change_o` stays 0.
- Multi-bit: `switch_raw` = 24'hA5_00FF applied in one cycle → `switch_o` = 24'hA5_00FF, all bits updating on the same edge.
- Reset mid-count: bit 3 high for 8 cycles, then `switrst` pulsed → `cnt`, `switch_o` and `change_o` are 0 immediately. After release with bit 3 still high, it is accepted a full debounce period later.
- Change latch (macro on): bit 7 flips, then `chg_clr` with mask 24'h000080 → `irq_o` 1→0. A second test issues `chg_clr` on the same edge bit 7 flips again → `change_o`[7] stays 1.
- Macro off: same stimulus → `change_o`=0 and `irq_o`=0 always; `switch_o` behaviour is identical to the macro-on build.
